dpd_layer_scheduler: RTL

// - Sequences one shared PAR-lane MAC datapath through the DPD backbone for each input sample.
// - Order: hidden FC layer (fan-in IN_SIZE), then output FC layer (fan-in HID_SIZE*(1+DENSE), dense concat).
// - Emits weight/bias addresses, activation-chunk selects, lane masks, accumulator control and write-back strobes.
// - Sits between the feature-extraction stage (s_*) and the I/Q output register (m_*).

---
 rtl/dpd_layer_scheduler_pkg.sv | 35 +++
 rtl/dpd_layer_scheduler_wb_delay.sv | 42 ++++
 rtl/dpd_layer_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dpd_layer_scheduler_pkg.sv
// Shared state type and derived sizes for the DPD layer scheduler.
package dpd_sched_pack;

  localparam int IN_SIZE  = 14;
  localparam int HID_SIZE = 12;
  localparam int OUT_SIZE = 2;
  localparam int PAR      = 3;
  localparam int DENSE    = 1;

  localparam int FAN1     = HID_SIZE * (1 + DENSE);
  localparam int CH0      = (IN_SIZE + PAR - 1) / PAR;
  localparam int CH1      = (FAN1 + PAR - 1) / PAR;
  localparam int BASE1    = HID_SIZE * CH0;
  localparam int TOTAL_CH = BASE1 + OUT_SIZE * CH1;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW = width_of(TOTAL_CH);
  localparam int NW = width_of(HID_SIZE + OUT_SIZE);
  localparam int IW = width_of((IN_SIZE > HID_SIZE) ? IN_SIZE : HID_SIZE);
  localparam int EW = width_of(FAN1);
  localparam int CW = width_of((CH1 > CH0) ? CH1 : CH0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN0   = 3'd1,
    DRAIN0 = 3'd2,
    RUN1   = 3'd3,
    DRAIN1 = 3'd4,
    DONE   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/dpd_layer_scheduler_wb_delay.sv
// Fixed-depth valid/tag delay matching the MAC accumulate latency; depth 0 is a wire.
module dpd_wb_delay #(
  parameter int DEPTH = 3,
  parameter int TW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [TW-1:0] out_tag
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_tag   = in_tag;
    end else begin : g_pipe
      logic [DEPTH-1:0] v_r;
      logic [TW-1:0]    t_r [DEPTH];

      // shift stage 0 from the input, later stages from their predecessor
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_r <= '0;
          for (int i = 0; i < DEPTH; i++) t_r[i] <= '0;
        end else begin
          v_r[0] <= in_valid;
          t_r[0] <= in_tag;
          for (int i = 1; i < DEPTH; i++) begin
            v_r[i] <= v_r[i-1];
            t_r[i] <= t_r[i-1];
          end
        end
      end

      assign out_valid = v_r[DEPTH-1];
      assign out_tag   = t_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dpd_layer_scheduler.sv
// Sequences one shared PAR-lane MAC through the hidden and output FC layers per sample.
// Optional macro SCHED_PERF_EN adds the perf_busy / perf_stall counters.
module dpd_layer_scheduler
  import dpd_sched_pack::*;
#(
  parameter int MAC_LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [AW-1:0]  w_addr,
  output logic [NW-1:0]  b_addr,
  output logic           layer,
  output logic           act_src,
  output logic [IW-1:0]  act_base,
  output logic [PAR-1:0] lane_mask,
  output logic           issue,
  output logic           acc_clr,
  output logic           acc_last,
  output logic           wb_valid,
  output logic           wb_layer,
  output logic [NW-1:0]  wb_idx
`ifdef SCHED_PERF_EN
  ,
  output logic [15:0]    perf_busy,
  output logic [15:0]    perf_stall
`endif
);

  sched_state_e  state;
  logic [CW-1:0] chunk;
  logic [NW-1:0] neuron;
  logic [NW-1:0] issue_n;
  logic [AW-1:0] addr;
  logic [EW-1:0] elem;

  logic           hs_s;
  logic           drain_done_s;
  logic           go_s;
  logic           go_layer_s;
  logic           last_chunk_s;
  logic           last_neuron_s;
  logic           src_s;
  logic [IW-1:0]  base_s;
  logic [PAR-1:0] mask_s;

  assign hs_s = (state == IDLE) && s_valid && s_ready;

  // next-issue decode; DRAIN0 issues the first layer-1 chunk on the cycle it exits
  always_comb begin
    go_layer_s = (state == RUN1) || (state == DRAIN0);
    if (state == DRAIN0) begin
      drain_done_s = wb_valid && !wb_layer && (wb_idx == NW'(HID_SIZE - 1));
    end else if (state == DRAIN1) begin
      drain_done_s = wb_valid && wb_layer && (wb_idx == NW'(OUT_SIZE - 1));
    end else begin
      drain_done_s = 1'b0;
    end
    go_s = hs_s || (state == RUN0) || (state == RUN1) || ((state == DRAIN0) && drain_done_s);
    last_chunk_s  = (chunk == (go_layer_s ? CW'(CH1 - 1) : CW'(CH0 - 1)));
    last_neuron_s = (neuron == (go_layer_s ? NW'(OUT_SIZE - 1) : NW'(HID_SIZE - 1)));
    for (int k = 0; k < PAR; k++) begin
      mask_s[k] = ((int'(elem) + k) < (go_layer_s ? FAN1 : IN_SIZE));
    end
    if (go_layer_s && (elem >= EW'(HID_SIZE))) begin
      src_s  = 1'b0;
      base_s = IW'(elem - EW'(HID_SIZE));
    end else begin
      src_s  = go_layer_s;
      base_s = IW'(elem);
    end
  end

  // scheduler FSM with chunk/neuron/address counters and registered MAC controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      chunk     <= '0;
      neuron    <= '0;
      issue_n   <= '0;
      addr      <= '0;
      elem      <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      layer     <= 1'b0;
      act_src   <= 1'b0;
      act_base  <= '0;
      lane_mask <= '0;
      issue     <= 1'b0;
      acc_clr   <= 1'b0;
      acc_last  <= 1'b0;
    end else begin
      issue     <= go_s;
      acc_clr   <= go_s && (chunk == '0);
      acc_last  <= go_s && last_chunk_s;
      lane_mask <= go_s ? mask_s : '0;
      if (go_s) begin
        w_addr   <= addr;
        b_addr   <= go_layer_s ? (NW'(HID_SIZE) + neuron) : neuron;
        layer    <= go_layer_s;
        act_src  <= src_s;
        act_base <= base_s;
        issue_n  <= neuron;
        addr     <= (go_layer_s && last_chunk_s && last_neuron_s) ? '0 : (addr + AW'(1));
        if (last_chunk_s) begin
          chunk  <= '0;
          elem   <= '0;
          neuron <= last_neuron_s ? '0 : (neuron + NW'(1));
        end else begin
          chunk  <= chunk + CW'(1);
          elem   <= elem + EW'(PAR);
        end
      end
      case (state)
        IDLE: begin
          s_ready <= !hs_s;
          if (hs_s) state <= RUN0;
        end
        RUN0:   if (last_chunk_s && last_neuron_s) state <= DRAIN0;
        DRAIN0: if (drain_done_s) state <= RUN1;
        RUN1:   if (last_chunk_s && last_neuron_s) state <= DRAIN1;
        DRAIN1: begin
          if (drain_done_s) begin
            state   <= DONE;
            m_valid <= 1'b1;
          end
        end
        DONE: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  dpd_wb_delay #(
    .DEPTH (MAC_LAT),
    .TW    (NW + 1)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (acc_last),
    .in_tag    ({layer, issue_n}),
    .out_valid (wb_valid),
    .out_tag   ({wb_layer, wb_idx})
  );

`ifdef SCHED_PERF_EN
  logic [15:0] busy_cnt;

  // busy_cnt counts from the handshake edge so the latched value equals the m_valid latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt   <= 16'd0;
      perf_busy  <= 16'd0;
      perf_stall <= 16'd0;
    end else begin
      if (hs_s) begin
        busy_cnt <= 16'd1;
      end else if (busy_cnt != 16'hFFFF) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
      if ((state == DRAIN1) && drain_done_s) perf_busy <= busy_cnt + 16'd1;
      if (hs_s) begin
        perf_stall <= 16'd0;
      end else if ((state == DONE) && !m_ready && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule
